// File: rtl/scaler_ctrl.sv
// scaler_ctrl: sequencer for the frame-scaling datapath.
// A start request latches the algorithm select and clears the frame RAM to
// CLEAR_VAL. The engine is then released from reset and its RAM write port is
// forwarded until it reports done, guarded by a watchdog that reports ERROR.
module scaler_ctrl #(
    parameter int                 ADDR_W      = 19,
    parameter int                 DATA_W      = 8,
    parameter int                 RAM_DEPTH   = 76800,
    parameter logic [DATA_W-1:0]  CLEAR_VAL   = 8'h00,
    parameter int                 TIMEOUT_CYC = 200000,
    parameter int                 CNT_W       = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    output logic              eng_rst,
    output logic [1:0]        eng_sel,
    input  logic              eng_done,
    input  logic [ADDR_W-1:0] eng_wraddr,
    input  logic [DATA_W-1:0] eng_data,
    input  logic              eng_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              done_pulse,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_WDOG = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic [1:0]          eng_sel_q, eng_sel_d;
    logic                done_pulse_q, done_pulse_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_addr_q   <= '0;
            wdog_q       <= '0;
            eng_sel_q    <= 2'b00;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wdog_q       <= wdog_d;
            eng_sel_q    <= eng_sel_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Next-state logic: sequencing, clear address, watchdog, mode latch
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wdog_d     = wdog_q;
        eng_sel_d  = eng_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    eng_sel_d  = mode_sel;
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // Last address is written this cycle; the address wraps to 0
                // so the idle-time address output reads back as zero.
                if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d = '0;
                    state_d    = ST_ARM;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_ARM: begin
                wdog_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wdog_d = wdog_q + CNT_W'(1);
                // Completion wins over a simultaneous watchdog expiry
                if (eng_done) begin
                    state_d = ST_DONE;
                end else if (wdog_q == LAST_WDOG) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // A switch change alone re-runs the frame with the new algorithm
                if (start || (mode_sel != eng_sel_q)) begin
                    eng_sel_d  = mode_sel;
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end else begin
                    state_d    = ST_DONE;
                end
            end
            ST_ERROR: begin
                if (start) begin
                    eng_sel_d  = mode_sel;
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end else begin
                    state_d    = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_pulse_d = (state_q == ST_RUN) && (state_d == ST_DONE);
    end

    // Output decode from registered state; RUN forwards the engine write port
    always_comb begin
        eng_rst    = 1'b1;
        ram_wren   = 1'b0;
        ram_wraddr = clr_addr_q;
        ram_data   = CLEAR_VAL;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                eng_rst = 1'b1;
            end
            ST_CLEAR: begin
                ram_wren = 1'b1;
                busy     = 1'b1;
            end
            ST_ARM: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                eng_rst    = 1'b0;
                ram_wraddr = eng_wraddr;
                ram_data   = eng_data;
                ram_wren   = eng_wren;
                busy       = 1'b1;
            end
            ST_DONE: begin
                // Engine stays out of reset so it keeps presenting its done
                eng_rst = 1'b0;
                done    = 1'b1;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                eng_rst = 1'b1;
            end
        endcase
    end

    assign eng_sel    = eng_sel_q;
    assign done_pulse = done_pulse_q;

endmodule
